// File: rtl/ofu_pkg.sv
// Shared types and constants for the operand fetch unit.
// The indirect-operand states exist only when OFU_INDIRECT_EN is defined.
package ofu_pkg;

  localparam int OFU_MAX_FIELDS  = 8;
  localparam int OFU_MIN_LATENCY = 1;
  localparam int OFU_MAX_LATENCY = 4;
  localparam int OFU_IDX_W       = $clog2(OFU_MAX_FIELDS);
  localparam int OFU_LAT_W       = $clog2(OFU_MAX_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
`ifdef OFU_INDIRECT_EN
    ST_DONE      = 3'd3,
    ST_IND_ISSUE = 3'd4,
    ST_IND_WAIT  = 3'd5
`else
    ST_DONE      = 3'd3
`endif
  } ofu_state_e;

  // Terminal value of the wait counter; latency is clamped into the supported range.
  function automatic logic [OFU_LAT_W-1:0] ofu_last_lat(input int lat);
    int l;
    if (lat < OFU_MIN_LATENCY) begin
      l = OFU_MIN_LATENCY;
    end else if (lat > OFU_MAX_LATENCY) begin
      l = OFU_MAX_LATENCY;
    end else begin
      l = lat;
    end
    return OFU_LAT_W'(l - 1);
  endfunction

endpackage

// File: rtl/regn.sv
// Generic W-bit register: asynchronous active-low clear, synchronous write enable.
module regn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Fetches NUM_FIELDS consecutive instruction words into field registers for stage three.
// Define OFU_INDIRECT_EN to also fetch mem[field1] and mem[field2] as operands.
module operand_fetch_unit
  import ofu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_FIELDS  = 4,
  parameter int OP_W        = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic                         wrap,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_rd_data,
  output logic [NUM_FIELDS*DATA_W-1:0] fields_out,
  output logic [OP_W-1:0]              op_out,
  output logic [DATA_W-1:0]            operand_a,
  output logic [DATA_W-1:0]            operand_b
);

  localparam logic [OFU_LAT_W-1:0] LAT_LAST = ofu_last_lat(MEM_LATENCY);
  localparam logic [OFU_IDX_W-1:0] IDX_LAST = OFU_IDX_W'(NUM_FIELDS - 1);

  ofu_state_e state_r, state_n;
  logic [OFU_IDX_W-1:0] idx_r, idx_n;
  logic [OFU_LAT_W-1:0] lat_r, lat_n;
  logic [ADDR_W-1:0]    base_r, base_n;
  logic [ADDR_W-1:0]    addr_r, addr_n;
  logic                 rd_en_r, rd_en_n;
  logic                 busy_r, busy_n;
  logic                 done_r, done_n;
  logic                 valid_r, valid_n;
  logic                 wrap_r, wrap_n;
  logic                 cap_field;
  logic [NUM_FIELDS-1:0] field_we;
  logic [DATA_W-1:0]    field_q [NUM_FIELDS];
  logic [ADDR_W:0]      next_sum;

  // Carry out of this sum marks an address that wrapped past the top of memory.
  assign next_sum = {1'b0, base_r} + (ADDR_W+1)'(idx_r) + {{ADDR_W{1'b0}}, 1'b1};

`ifdef OFU_INDIRECT_EN
  logic ind_sel_r, ind_sel_n;
  logic opa_we, opb_we;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    lat_n     = lat_r;
    base_n    = base_r;
    addr_n    = addr_r;
    rd_en_n   = 1'b0;
    done_n    = 1'b0;
    valid_n   = valid_r;
    wrap_n    = wrap_r;
    cap_field = 1'b0;
`ifdef OFU_INDIRECT_EN
    ind_sel_n = ind_sel_r;
    opa_we    = 1'b0;
    opb_we    = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_ISSUE;
          base_n  = base_addr;
          idx_n   = '0;
          valid_n = 1'b0;
          wrap_n  = 1'b0;
          rd_en_n = 1'b1;
          addr_n  = base_addr;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
        lat_n   = '0;
      end
      ST_WAIT: begin
        if (lat_r == LAT_LAST) begin
          cap_field = 1'b1;
          if (idx_r < IDX_LAST) begin
            idx_n   = idx_r + OFU_IDX_W'(1);
            state_n = ST_ISSUE;
            rd_en_n = 1'b1;
            addr_n  = next_sum[ADDR_W-1:0];
            wrap_n  = wrap_r | next_sum[ADDR_W];
          end else begin
`ifdef OFU_INDIRECT_EN
            state_n   = ST_IND_ISSUE;
            ind_sel_n = 1'b0;
            rd_en_n   = 1'b1;
            addr_n    = ADDR_W'(field_q[1]);
`else
            state_n = ST_DONE;
            done_n  = 1'b1;
            valid_n = 1'b1;
`endif
          end
        end else begin
          lat_n = lat_r + OFU_LAT_W'(1);
        end
      end
`ifdef OFU_INDIRECT_EN
      ST_IND_ISSUE: begin
        state_n = ST_IND_WAIT;
        lat_n   = '0;
      end
      ST_IND_WAIT: begin
        if (lat_r == LAT_LAST) begin
          if (!ind_sel_r) begin
            opa_we    = 1'b1;
            ind_sel_n = 1'b1;
            state_n   = ST_IND_ISSUE;
            rd_en_n   = 1'b1;
            addr_n    = ADDR_W'(field_q[2]);
          end else begin
            opb_we  = 1'b1;
            state_n = ST_DONE;
            done_n  = 1'b1;
            valid_n = 1'b1;
          end
        end else begin
          lat_n = lat_r + OFU_LAT_W'(1);
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
    for (int i = 0; i < NUM_FIELDS; i++) begin
      field_we[i] = cap_field && (idx_r == OFU_IDX_W'(i));
    end
  end

  // Counters, latched base and registered status outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      idx_r   <= '0;
      lat_r   <= '0;
      base_r  <= '0;
      addr_r  <= '0;
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
`ifdef OFU_INDIRECT_EN
      ind_sel_r <= 1'b0;
`endif
    end else begin
      idx_r   <= idx_n;
      lat_r   <= lat_n;
      base_r  <= base_n;
      addr_r  <= addr_n;
      rd_en_r <= rd_en_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      valid_r <= valid_n;
      wrap_r  <= wrap_n;
`ifdef OFU_INDIRECT_EN
      ind_sel_r <= ind_sel_n;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    regn #(.W(DATA_W)) u_field (
      .clk   (CLK),
      .rst_n (reset),
      .we    (field_we[gi]),
      .d     (mem_rd_data),
      .q     (field_q[gi])
    );
    assign fields_out[gi*DATA_W +: DATA_W] = field_q[gi];
  end

`ifdef OFU_INDIRECT_EN
  regn #(.W(DATA_W)) u_operand_a (
    .clk   (CLK),
    .rst_n (reset),
    .we    (opa_we),
    .d     (mem_rd_data),
    .q     (operand_a)
  );

  regn #(.W(DATA_W)) u_operand_b (
    .clk   (CLK),
    .rst_n (reset),
    .we    (opb_we),
    .d     (mem_rd_data),
    .q     (operand_b)
  );
`else
  assign operand_a = {DATA_W{1'b0}};
  assign operand_b = {DATA_W{1'b0}};
`endif

  assign op_out    = field_q[0][OP_W-1:0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign valid     = valid_r;
  assign wrap      = wrap_r;
  assign mem_rd_en = rd_en_r;
  assign mem_addr  = addr_r;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench: two fetch units (latency 1 and 3) share stimulus; each is checked every cycle
// against a timeline model derived from the fetch rules, plus literal directed checks.
module tb_operand_fetch_unit;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int NF  = 4;
  localparam int OPW = 8;
`ifdef OFU_INDIRECT_EN
  localparam int NR = NF + 2;
`else
  localparam int NR = NF;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] mem [0:65535];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L   = (gi == 0) ? 1 : 3;
    localparam int TOT = NR * (L + 1);

    logic            busy, done, valid, wrap, rd_en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   rd_data;
    logic [NF*DW-1:0] fields;
    logic [OPW-1:0]  op;
    logic [DW-1:0]   opa, opb;
    logic [DW-1:0]   pipe [L];

    operand_fetch_unit #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_FIELDS(NF), .OP_W(OPW), .MEM_LATENCY(L)
    ) u_dut (
      .CLK(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .valid(valid), .wrap(wrap),
      .mem_rd_en(rd_en), .mem_addr(addr), .mem_rd_data(rd_data),
      .fields_out(fields), .op_out(op), .operand_a(opa), .operand_b(opb)
    );

    // memory: L-stage read pipeline
    always @(posedge clk) begin
      pipe[0] <= (rd_en === 1'b1) ? mem[addr] : 16'h0000;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[L-1];

    // model: cycle position since the accepted start, snapshot of expected results
    bit            active = 1'b0;
    bit            mvalid = 1'b0;
    bit            fresh  = 1'b1;
    bit            mwrap  = 1'b0;
    int            rel    = 0;
    logic [AW-1:0] mbase  = '0;
    logic [DW-1:0] mf [NF];
    logic [DW-1:0] ma, mb;

    always @(posedge clk) begin
      if (!reset) begin
        active <= 1'b0; mvalid <= 1'b0; fresh <= 1'b1; rel <= 0;
      end else if ((!active || rel == TOT) && start) begin
        active <= 1'b1; rel <= 0; mbase <= base_addr;
        mvalid <= 1'b0; fresh <= 1'b0; mwrap <= 1'b0;
        for (int i = 0; i < NF; i++) begin
          mf[i] <= mem[16'(base_addr + i)];
          if (int'(base_addr) + i > 65535) mwrap <= 1'b1;
        end
        ma <= mem[mem[16'(base_addr + 1)]];
        mb <= mem[mem[16'(base_addr + 2)]];
      end else if (active) begin
        if (rel == TOT) active <= 1'b0;
        else begin
          rel <= rel + 1;
          if (rel + 1 == TOT) mvalid <= 1'b1;
        end
      end
    end

    bit e_done, e_valid, e_rd;
    int k;
    logic [AW-1:0] e_addr;
    logic [NF*DW-1:0] e_fields;

    always @(negedge clk) begin
      if (!reset) begin
        check($sformatf("L%0d rst busy", L), busy, 0);
        check($sformatf("L%0d rst done", L), done, 0);
        check($sformatf("L%0d rst valid", L), valid, 0);
        check($sformatf("L%0d rst wrap", L), wrap, 0);
        check($sformatf("L%0d rst rd_en", L), rd_en, 0);
        check($sformatf("L%0d rst addr", L), addr, 0);
        check($sformatf("L%0d rst fields", L), fields, 0);
        check($sformatf("L%0d rst opab", L), {opa, opb}, 0);
      end else begin
        e_done  = active && rel == TOT;
        e_valid = active ? e_done : mvalid;
        e_rd    = active && rel < TOT && (rel % (L + 1)) == 0;
        check($sformatf("L%0d busy", L), busy, active);
        check($sformatf("L%0d done", L), done, e_done);
        check($sformatf("L%0d valid", L), valid, e_valid);
        check($sformatf("L%0d rd_en", L), rd_en, e_rd);
        if (e_rd) begin
          k = rel / (L + 1);
          e_addr = (k < NF) ? 16'(mbase + k) : ((k == NF) ? mf[1] : mf[2]);
          check($sformatf("L%0d addr", L), addr, e_addr);
        end
        if (e_valid) begin
          for (int i = 0; i < NF; i++) e_fields[i*DW +: DW] = mf[i];
          check($sformatf("L%0d fields", L), fields, e_fields);
          check($sformatf("L%0d op", L), op, mf[0][OPW-1:0]);
          check($sformatf("L%0d wrap", L), wrap, mwrap);
`ifdef OFU_INDIRECT_EN
          check($sformatf("L%0d operand_a", L), opa, ma);
          check($sformatf("L%0d operand_b", L), opb, mb);
`else
          check($sformatf("L%0d operands", L), {opa, opb}, 0);
`endif
        end else if (fresh) begin
          check($sformatf("L%0d fresh fields", L), fields, 0);
        end
      end
    end
  end

  task automatic launch(input logic [AW-1:0] b);
    @(posedge clk); #2;
    start = 1'b1; base_addr = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    start = 1'b0;
    do begin
      @(negedge clk); n++;
    end while ((g_dut[0].busy || g_dut[1].busy) && n < 200);
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, npulse;
    logic [AW-1:0] paddr [8];
    for (int a = 0; a < 65536; a++) mem[a] = 16'd69;
    mem[100] = 16'd1023; mem[101] = 16'd10; mem[102] = 16'd45; mem[103] = 16'd7;
    mem[10] = 16'd55; mem[45] = 16'd69;
    for (int a = 300; a < 1300; a++) mem[a] = 16'($urandom);

    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("reset busy", g_dut[0].busy, 0);
    check("reset fields", g_dut[1].fields, 0);

    // latency 1 and 3, base 100
    launch(16'd100);
    d0 = -1; d1 = -1; npulse = 0;
    for (int n = 0; n < 80 && (d0 < 0 || d1 < 0); n++) begin
      @(negedge clk);
      if (g_dut[0].done && d0 < 0) d0 = n;
      if (g_dut[1].done && d1 < 0) d1 = n;
      if (g_dut[1].rd_en) begin
        if (npulse < 8) paddr[npulse] = g_dut[1].addr;
        npulse++;
      end
    end
`ifdef OFU_INDIRECT_EN
    check("L1 done edge", d0, 12);
    check("L3 done edge", d1, 24);
    check("L3 rd pulses", npulse, 6);
    check("L1 operand_a", g_dut[0].opa, 16'd55);
    check("L1 operand_b", g_dut[0].opb, 16'd69);
`else
    check("L1 done edge", d0, 8);
    check("L3 done edge", d1, 16);
    check("L3 rd pulses", npulse, 4);
`endif
    check("L3 addr0", paddr[0], 16'd100);
    check("L3 addr3", paddr[3], 16'd103);
    check("L1 fields", g_dut[0].fields, 64'h0007_002D_000A_03FF);
    check("L1 op", g_dut[0].op, 8'd255);
    check("L1 valid", g_dut[0].valid, 1);
    check("L1 wrap", g_dut[0].wrap, 0);
    wait_idle();

    // ignored start mid-fetch, then start held during DONE
    launch(16'd100);
    repeat (2) @(posedge clk);
    #2 start = 1'b1; base_addr = 16'd200;
    @(posedge clk); #2 start = 1'b0; base_addr = 16'd100;
    for (int n = 0; n < 40 && !g_dut[0].done; n++) @(negedge clk);
    check("L1 done seen", g_dut[0].done, 1);
    start = 1'b1;
    @(negedge clk);
    check("restart rd_en", g_dut[0].rd_en, 1);
    check("restart addr", g_dut[0].addr, 16'd100);
    start = 1'b0;
    wait_idle();

    // address wrap
    launch(16'd65534);
    wait_idle();
    check("wrap set", g_dut[0].wrap, 1);
    launch(16'd5);
    wait_idle();
    check("wrap cleared", g_dut[0].wrap, 0);

    // reset mid-fetch
    launch(16'd100);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst busy", g_dut[0].busy, 0);
    check("midrst rd_en", g_dut[0].rd_en, 0);
    check("midrst fields", g_dut[0].fields, 0);
    check("midrst done", {g_dut[0].done, g_dut[1].done}, 0);
    check("midrst L3 busy", g_dut[1].busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("post rst idle", {g_dut[0].busy, g_dut[1].busy}, 0);

    // randomized phase
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #2;
      start = 1'b1;
      for (int h = $urandom_range(1, 12); h > 0; h--) begin
        base_addr = ($urandom_range(0, 3) == 0) ? 16'(65530 + $urandom_range(0, 5))
                                               : 16'($urandom_range(300, 1290));
        @(posedge clk); #2;
      end
      start = 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
      end
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
